// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer and the hazard unit.
//   - MIPS funct codes for the HI/LO instruction group
//   - FSM state encoding
//   - iteration count and small op-decode helpers
package muldiv_pkg;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Multi-cycle ops that occupy the sequencer.
  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  // Ops whose operands are two's-complement.
  function automatic logic is_signed_op(input logic [5:0] op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX stage and the mul/div sequencer.
//   master (pipeline): drives i_start, i_op, i_op1, i_op2, i_flush
//   slave  (muldiv_ctrl): drives o_busy, o_done, o_hi, o_lo
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [5:0]       i_op;
  logic [WIDTH-1:0] i_op1;
  logic [WIDTH-1:0] i_op2;
  logic             i_flush;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_op1, i_op2, i_flush,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_op1, i_op2, i_flush,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the shared multiply/divide datapath (combinational).
//   work_i   : {hi-part, lo-part} working register
//              multiply: {accumulator, multiplier}
//              divide  : {remainder, dividend/quotient}
//   opnd_i   : multiplicand (mul) or divisor (div), unsigned
//   is_div_i : 1 selects restoring divide, 0 selects shift-add multiply
//   work_o   : working register after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] work_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] work_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           qbit;

  always_comb begin
    // Multiply: add multiplicand when the multiplier LSB is set, then shift
    // the whole register right; the carry enters the top of the accumulator.
    sum = {1'b0, work_i[2*WIDTH-1:WIDTH]};
    if (work_i[0]) begin
      sum = sum + {1'b0, opnd_i};
    end

    // Divide: shift {rem, quot} left by one and trial-subtract. The remainder
    // is always below the divisor, so the shifted value fits WIDTH+1 bits and
    // bit WIDTH of the difference is the borrow.
    rem_sh = work_i[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd_i};
    qbit   = ~diff[WIDTH];

    if (is_div_i) begin
      work_o = {(qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                work_i[WIDTH-2:0], qbit};
    end else begin
      work_o = {sum, work_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO.
// MTHI/MTLO write HI/LO in a single cycle without leaving IDLE.
//   i_clk, i_rst : clock (rising edge), synchronous active-high reset
//   bus (slave)  : i_start/i_op/i_op1/i_op2/i_flush issue side,
//                  o_busy/o_done/o_hi/o_lo result side
// Latency: accept edge k, iterations on k+1..k+32, sign fix and HI/LO write
// on k+33, o_done high for the following cycle.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic     i_clk,
  input logic     i_rst,
  muldiv_if.slave bus
);
  import muldiv_pkg::*;

  localparam int W2 = 2 * WIDTH;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [W2-1:0]      work_q;
  logic [W2-1:0]      work_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic               qneg_q;
  logic               rneg_q;
  logic               div0_q;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q;

  logic               sgn_op;
  logic               div_op;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [W2-1:0]      prod_neg;

  // abs(0x80000000) stays 0x80000000 and is then treated as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic            sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign sgn_op = is_signed_op(bus.i_op);
  assign div_op = is_div_op(bus.i_op);
  assign a_abs  = abs_val(bus.i_op1, sgn_op);
  assign b_abs  = abs_val(bus.i_op2, sgn_op);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .work_i   (work_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .work_o   (work_d)
  );

  // Sign fix applied on the FIX edge. A zero divisor leaves the quotient at
  // all ones, and the remainder (|op1| re-negated by op1's sign) equals op1.
  always_comb begin
    prod_neg = -work_q;
    hi_d     = work_q[W2-1:WIDTH];
    lo_d     = work_q[WIDTH-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        lo_d = '1;
      end else if (qneg_q) begin
        lo_d = -work_q[WIDTH-1:0];
      end
      if (rneg_q) begin
        hi_d = -work_q[W2-1:WIDTH];
      end
    end else if (qneg_q) begin
      hi_d = prod_neg[W2-1:WIDTH];
      lo_d = prod_neg[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_start && !bus.i_flush) begin
            if (is_muldiv(bus.i_op)) begin
              state_q  <= RUN;
              cnt_q    <= '0;
              is_div_q <= div_op;
              qneg_q   <= sgn_op && (bus.i_op1[WIDTH-1] ^ bus.i_op2[WIDTH-1]);
              rneg_q   <= sgn_op && bus.i_op1[WIDTH-1];
              div0_q   <= (bus.i_op2 == '0);
              if (div_op) begin
                work_q <= {{WIDTH{1'b0}}, a_abs};
                opnd_q <= b_abs;
              end else begin
                work_q <= {{WIDTH{1'b0}}, b_abs};
                opnd_q <= a_abs;
              end
            end else if (bus.i_op == MTHI) begin
              hi_q <= bus.i_op1;
            end else if (bus.i_op == MTLO) begin
              lo_q <= bus.i_op1;
            end
          end
        end
        RUN: begin
          if (bus.i_flush) begin
            state_q <= IDLE;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER - 1)) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          if (bus.i_flush) begin
            state_q <= IDLE;
          end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_busy = (state_q != IDLE);
  assign bus.o_done = done_q;
  assign bus.o_hi   = hi_q;
  assign bus.o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO pairs are queued when an op
// is issued; a monitor pops and compares on every o_done pulse.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got o_done=1, want no result pending");
        end else begin
          mon_e = sb_q.pop_front();
          chk({mon_e.name, "_hi"}, bus.o_hi, mon_e.hi);
          chk({mon_e.name, "_lo"}, bus.o_lo, mon_e.lo);
        end
      end
    end
  end

  task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_op1   = a;
    bus.i_op2   = b;
  endtask

  // Returns at the negedge where o_done is seen; counts busy cycles on the way.
  task automatic wait_done(input string name, output int busy_cyc);
    int  n;
    bit  seen;
    busy_cyc = 0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_busy === 1'b1) busy_cyc++;
      if (bus.o_done === 1'b1) seen = 1'b1;
      n++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no o_done in %0d cycles, want o_done", name, n);
    end
  endtask

  task automatic single(input logic [5:0] op, input logic [31:0] v);
    drive(op, v, 32'h0);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    int c;
    push(name, hi, lo);
    drive(op, a, b);
    wait_done(name, c);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_op    = 6'h0;
    bus.i_op1   = 32'h0;
    bus.i_op2   = 32'h0;
    bus.i_flush = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, bus.o_busy}, 32'h0);
    chk("rst_done", {31'b0, bus.o_done}, 32'h0);
    chk("rst_hi", bus.o_hi, 32'h0);
    chk("rst_lo", bus.o_lo, 32'h0);
    rst = 1'b0;

    // Unsigned multiply, full-scale operands; busy for exactly 33 cycles.
    push("multu_ff", 32'hFFFFFFFE, 32'h00000001);
    drive(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_ff", cyc);
    chk("multu_busy_cycles", cyc, 32'd33);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, bus.o_done}, 32'h0);

    // Signed multiply, then divide issued in the o_done cycle.
    push("mult_m3x5", 32'hFFFFFFFF, 32'hFFFFFFF1);
    drive(MULT, 32'hFFFFFFFD, 32'd5);
    wait_done("mult_m3x5", cyc);
    push("div_m7d2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    drive(DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_m7d2", cyc);
    chk("b2b_busy_cycles", cyc, 32'd33);

    // Divide boundaries.
    run_op("divu_by0", DIVU, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_m7_by0", DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_7dm2", DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

    // MTHI / MTLO single-cycle writes.
    @(negedge clk);
    single(MTHI, 32'h12345678);
    chk("mthi_hi", bus.o_hi, 32'h12345678);
    chk("mthi_busy", {31'b0, bus.o_busy}, 32'h0);
    single(MTLO, 32'h9ABCDEF0);
    chk("mtlo_lo", bus.o_lo, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", bus.o_hi, 32'h12345678);
    chk("mtlo_done", {31'b0, bus.o_done}, 32'h0);

    // Unknown op and MFHI are ignored by the sequencer.
    single(6'b100000, 32'hDEADBEEF);
    chk("unk_busy", {31'b0, bus.o_busy}, 32'h0);
    single(MFHI, 32'hDEADBEEF);
    chk("mfhi_busy", {31'b0, bus.o_busy}, 32'h0);
    chk("unk_hi_kept", bus.o_hi, 32'h12345678);
    chk("unk_lo_kept", bus.o_lo, 32'h9ABCDEF0);

    run_op("divu_100d7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // Flush mid-run with ignored start pulses.
    @(negedge clk);
    single(MTHI, 32'hAAAAAAAA);
    single(MTLO, 32'h55555555);
    drive(MULTU, 32'd5, 32'd6);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      bus.i_start = (i >= 3 && i <= 5);
      if (i == 3) begin
        bus.i_op  = MULT;
        bus.i_op1 = 32'd9;
        bus.i_op2 = 32'd9;
      end
      if (i == 10) begin
        chk("flush_busy_run10", {31'b0, bus.o_busy}, 32'h1);
        bus.i_flush = 1'b1;
      end
      if (i == 11) begin
        bus.i_flush = 1'b0;
        chk("flush_busy_after", {31'b0, bus.o_busy}, 32'h0);
      end
    end
    chk("flush_hi_kept", bus.o_hi, 32'hAAAAAAAA);
    chk("flush_lo_kept", bus.o_lo, 32'h55555555);
    repeat (40) @(negedge clk);
    chk("flush_no_restart", {31'b0, bus.o_busy}, 32'h0);

    // Flush in IDLE blocks a simultaneous start.
    drive(MULTU, 32'd3, 32'd3);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    chk("idle_flush_block", {31'b0, bus.o_busy}, 32'h0);

    // Reset mid-divide discards the operation.
    drive(DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk) bus.i_start = 1'b0;
    chk("div_running", {31'b0, bus.o_busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'b0, bus.o_busy}, 32'h0);
    chk("midrst_done", {31'b0, bus.o_done}, 32'h0);
    chk("midrst_hi", bus.o_hi, 32'h0);
    chk("midrst_lo", bus.o_lo, 32'h0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_idle", {31'b0, bus.o_busy}, 32'h0);

    chk("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
